// File: rtl/song_sequencer.sv
// song_sequencer: walks one song's region of a song ROM, decodes note and
// advance entries, hands notes round-robin to NUM_VOICES voice slots and
// waits on beat strobes for advance entries. Supports pause, song switching
// and an optional loop-at-end mode.
module song_sequencer #(
  parameter int ADDR_WIDTH = 7,
  parameter int SONG_BITS  = 2,
  parameter int NUM_VOICES = 3,
  parameter int LOOP       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SONG_BITS-1:0]    song_sel,
  input  logic                    beat,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [15:0]             rom_dout,
  output logic [6*NUM_VOICES-1:0] note_out,
  output logic [6*NUM_VOICES-1:0] dur_out,
  output logic [NUM_VOICES-1:0]   new_note,
  output logic                    song_done,
  output logic                    busy
);

  localparam int OFF_W = ADDR_WIDTH - SONG_BITS;
  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_DECODE   = 3'd3;
  localparam logic [2:0] S_BEATWAIT = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;

  localparam logic [OFF_W-1:0] LAST_OFF = '1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_VOICES - 1);

  logic [2:0]           state;
  logic [SONG_BITS-1:0] song_reg;
  logic [OFF_W-1:0]     offset;
  logic [5:0]           beat_cnt;
  logic [PTR_W-1:0]     ptr;

  // Entry fields: bit 15 selects advance (1) or note (0); [14:9] is the note
  // number or beat count, [8:3] the note duration, [2:0] carries nothing.
  logic       entry_adv;
  logic [5:0] entry_val;
  logic [5:0] entry_dur;
  logic       unused_low_bits;

  assign entry_adv       = rom_dout[15];
  assign entry_val       = rom_dout[14:9];
  assign entry_dur       = rom_dout[8:3];
  assign unused_low_bits = ^rom_dout[2:0];

  // A new selection while running restarts the new song from offset 0; it
  // overrides everything the current state would otherwise do this cycle.
  logic song_change;
  assign song_change = play && (state != S_IDLE) && (song_sel != song_reg);

  assign busy = (state != S_IDLE);

  // Sequencer FSM, fetch address, voice outputs and one-cycle pulses.
  // While paused only ADDR and BEATWAIT stall: a fetch already issued drains
  // through WAIT/DECODE/NEXT so no entry is lost, and the next fetch waits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      song_reg  <= '0;
      offset    <= '0;
      beat_cnt  <= '0;
      ptr       <= '0;
      rom_addr  <= '0;
      note_out  <= '0;
      dur_out   <= '0;
      new_note  <= '0;
      song_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below
      // are overridden later in the same block, last assignment wins.
      new_note  <= '0;
      song_done <= 1'b0;
      if (song_change) begin
        song_reg <= song_sel;
        offset   <= '0;
        beat_cnt <= '0;
        ptr      <= '0;
        state    <= S_ADDR;
      end else begin
        case (state)
          S_IDLE: begin
            if (play) begin
              song_reg <= song_sel;
              offset   <= '0;
              state    <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (play) begin
              rom_addr <= {song_reg, offset};
              state    <= S_WAIT;
            end
          end
          S_WAIT: state <= S_DECODE;
          S_DECODE: begin
            if (!entry_adv) begin
              // Note 0 is a rest: it takes its slot in time but no voice.
              if (entry_val != 6'd0) begin
                note_out[6*ptr +: 6] <= entry_val;
                dur_out[6*ptr +: 6]  <= entry_dur;
                new_note[ptr]        <= 1'b1;
                ptr                  <= (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
              end
              state <= S_NEXT;
            end else if (entry_val == 6'd0) begin
              state <= S_NEXT;
            end else begin
              beat_cnt <= entry_val;
              state    <= S_BEATWAIT;
            end
          end
          S_BEATWAIT: begin
            if (play && beat) begin
              beat_cnt <= beat_cnt - 6'd1;
              if (beat_cnt == 6'd1) state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (offset == LAST_OFF) begin
              song_done <= 1'b1;
              offset    <= '0;
              if (LOOP != 0) begin
                state <= S_ADDR;
              end else begin
                ptr   <= '0;
                state <= S_IDLE;
              end
            end else begin
              offset <= offset + 1'b1;
              state  <= S_ADDR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
